// File: rtl/fifo_word_serializer.sv
// fifo_word_serializer: drains words from a show-ahead FIFO and shifts each one
// out as a valid/ready bit stream, flagging the final bit of every word.
// Revision 1.0
`default_nettype none

module fifo_word_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_read_data,
  output logic             fifo_pop,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_data,
  output logic             sout_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             accept;
  logic             load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;

    sout_valid = (state == SHIFT);
    sout_last  = sout_valid & (cnt == LAST_CNT);
    // Gate the data so an idle link presents a clean zero rather than stale bits.
    sout_data  = sout_valid & (LSB_FIRST ? shreg[0] : shreg[WIDTH-1]);
    busy       = sout_valid;

    accept   = sout_valid & sout_ready;
    load     = ~fifo_empty & ((state == IDLE) | (accept & sout_last));
    fifo_pop = load;

    if (load) begin
      shreg_next = fifo_read_data;
      cnt_next   = '0;
      state_next = SHIFT;
    end else if (accept & ~sout_last) begin
      shreg_next = LSB_FIRST ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};
      cnt_next   = cnt + 1'b1;
    end else if (accept) begin
      // Last bit gone and nothing queued: wrap the counter explicitly.
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_word_serializer.sv
// Bench for fifo_word_serializer: an 8-bit LSB-first and a 10-bit MSB-first
// instance, each fed from a bench-side FIFO and checked against a bit-stream model.
`default_nettype none

module tb_fifo_word_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       e0, e1, p0, p1, v0, v1, r0, r1, d0, d1, l0, l1, b0, b1;
  logic [7:0] rd0;
  logic [9:0] rd1;

  always #5 clk = ~clk;

  fifo_word_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut8 (
    .clk(clk), .rst(rst), .fifo_empty(e0), .fifo_read_data(rd0), .fifo_pop(p0),
    .sout_valid(v0), .sout_ready(r0), .sout_data(d0), .sout_last(l0), .busy(b0));

  fifo_word_serializer #(.WIDTH(10), .LSB_FIRST(1'b0)) dut10 (
    .clk(clk), .rst(rst), .fifo_empty(e1), .fifo_read_data(rd1), .fifo_pop(p1),
    .sout_valid(v1), .sout_ready(r1), .sout_data(d1), .sout_last(l1), .busy(b1));

  int errors = 0;
  int checks = 0;

  // Bench FIFOs and reference model: a word in flight plus count of bits already accepted.
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  bit          got0[$];
  bit          got1[$];
  bit          mb[2];
  logic [15:0] mw[2];
  int          mk[2];
  int          seen_pop0 = 0;
  int          wd[2] = '{8, 10};
  bit          lf[2] = '{1'b1, 1'b0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_bits(input string nm, input bit g[$], input logic [31:0] exp, input int n);
    logic [31:0] act;
    act = '0;
    foreach (g[j]) act = (act << 1) | 32'(g[j]);
    chk({nm, "_len"}, 32'(g.size()), 32'(n));
    chk(nm, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mb[i] = 1'b0;
      mk[i] = 0;
    end
  endtask

  task automatic cycle(input bit ra, input bit rb);
    bit   ep[2];
    bit   rdy[2];
    logic qe[2];
    logic dv[2], dd[2], dl[2], dp[2], db[2];
    r0 = ra;
    r1 = rb;
    e0 = (q0.size() == 0);
    e1 = (q1.size() == 0);
    rd0 = e0 ? 8'($urandom) : q0[0][7:0];
    rd1 = e1 ? 10'($urandom) : q1[0][9:0];
    #1;
    rdy = '{ra, rb};
    qe = '{e0, e1};
    dv = '{v0, v1}; dd = '{d0, d1}; dl = '{l0, l1}; dp = '{p0, p1}; db = '{b0, b1};
    for (int i = 0; i < 2; i++) begin
      ep[i] = !qe[i] && (!mb[i] || (rdy[i] && mk[i] == wd[i] - 1));
      chk($sformatf("pop%0d", i), 32'(dp[i]), 32'(ep[i]));
      chk($sformatf("valid%0d", i), 32'(dv[i]), 32'(mb[i]));
      chk($sformatf("busy%0d", i), 32'(db[i]), 32'(mb[i]));
      chk($sformatf("last%0d", i), 32'(dl[i]), 32'(mb[i] && mk[i] == wd[i] - 1));
      if (mb[i])
        chk($sformatf("data%0d", i), 32'(dd[i]),
            32'(mw[i][lf[i] ? mk[i] : wd[i] - 1 - mk[i]]));
    end
    if (v0 && r0) got0.push_back(d0);
    if (v1 && r1) got1.push_back(d1);
    if (p0) seen_pop0++;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (ep[i]) begin
        mw[i] = (i == 0) ? q0.pop_front() : q1.pop_front();
        mk[i] = 0;
        mb[i] = 1'b1;
      end else if (mb[i] && rdy[i]) begin
        if (mk[i] == wd[i] - 1) begin
          mb[i] = 1'b0;
          mk[i] = 0;
        end else begin
          mk[i]++;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int sp;
    int guard;
    rst = 1'b1;
    e0 = 1'b1; e1 = 1'b1; r0 = 1'b0; r1 = 1'b0; rd0 = '0; rd1 = '0;
    model_reset();
    #2;
    chk("rst_valid", 32'(v0), 0);
    chk("rst_data", 32'(d0), 0);
    chk("rst_last", 32'(l0), 0);
    chk("rst_pop", 32'(p0), 0);
    chk("rst_valid10", 32'(v1), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single word, full rate.
    q0.push_back(16'hA5);
    for (int j = 0; j < 10; j++) cycle(1'b1, 1'b1);
    chk_bits("single_a5", got0, 32'hA5, 8);
    chk("single_pops", 32'(seen_pop0), 1);

    // Back-to-back words with no bubble.
    got0.delete();
    q0.push_back(16'h0F);
    q0.push_back(16'hF0);
    for (int j = 0; j < 18; j++) cycle(1'b1, 1'b1);
    chk_bits("b2b", got0, 32'hF00F, 16);

    // Backpressure with ready pattern 1,0,0 repeating.
    got0.delete();
    q0.push_back(16'h81);
    for (int j = 0; j < 40; j++) cycle(j % 3 == 0, 1'b1);
    chk_bits("bp_81", got0, 32'h81, 8);

    // Stall on the last bit while the FIFO still holds a word.
    got0.delete();
    q0.push_back(16'h3C);
    q0.push_back(16'h55);
    cycle(1'b1, 1'b1);
    for (int j = 0; j < 7; j++) cycle(1'b1, 1'b1);
    sp = seen_pop0;
    for (int j = 0; j < 3; j++) cycle(1'b0, 1'b1);
    chk("stall_last_pop", 32'(seen_pop0 - sp), 0);
    cycle(1'b1, 1'b1);
    chk("release_pop", 32'(seen_pop0 - sp), 1);
    for (int j = 0; j < 10; j++) cycle(1'b1, 1'b1);
    chk_bits("stall_seq", got0, 32'h3CAA, 16);

    // 10-bit MSB-first instance.
    q1.push_back(16'h201);
    for (int j = 0; j < 12; j++) cycle(1'b1, 1'b1);
    chk_bits("msb_201", got1, 32'h201, 10);

    // Reset in the middle of a word drops it.
    q0.push_back(16'hFF);
    q0.push_back(16'h00);
    cycle(1'b1, 1'b1);
    for (int j = 0; j < 3; j++) cycle(1'b1, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(v0), 0);
    chk("midrst_last", 32'(l0), 0);
    model_reset();
    #1;
    rst = 1'b0;
    got0.delete();
    for (int j = 0; j < 12; j++) cycle(1'b1, 1'b1);
    chk_bits("after_rst", got0, 32'h00, 8);

    // Randomized traffic on both instances.
    for (int j = 0; j < 500; j++) begin
      if ($urandom_range(0, 3) != 0 && q0.size() < 4) q0.push_back(16'($urandom));
      if ($urandom_range(0, 3) != 0 && q1.size() < 4) q1.push_back(16'($urandom));
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end
    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0 || mb[0] || mb[1]) && guard < 200) begin
      cycle(1'b1, 1'b1);
      guard++;
    end
    if (guard >= 200) chk("drain_timeout", 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_word_serializer.md
Name: fifo_word_serializer

Overview:
- Pop-side consumer for the team's flip-flop FIFO (push/pop, show-ahead read data, empty/full).
- Drains words from the FIFO and emits each one as a serial bit stream on a valid/ready interface, with a last-bit marker per word.
- Sits between a word FIFO and a bit-serial link (e.g. a line encoder or shift-out pin driver).
- Sustains back-to-back words with no idle cycles while the FIFO is non-empty and the downstream is ready.

Parameters:
- width, 8, word width in bits; must be >= 2; need not be a power of two.
- lsb_first, 1, 1 = bit 0 of each word is sent first; 0 = bit width-1 is sent first.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- fifo_empty  input  1  FIFO empty flag
- fifo_read_data  input  width  FIFO head word; valid whenever fifo_empty is 0 (show-ahead)
- fifo_pop  output  1  pop strobe to FIFO; a word is consumed on every clk edge where it is 1
- sout_valid  output  1  serial bit valid
- sout_ready  input  1  downstream accepts the bit when sout_valid & sout_ready
- sout_data  output  1  current serial bit
- sout_last  output  1  1 on the final bit of a word
- busy  output  1  1 while a word is being shifted out (equals sout_valid)

Behaviour:
- States: IDLE, SHIFT. State register, shift register (width bits) and bit counter ($clog2(width) bits) are the only storage.
- Reset (async, immediate): state = IDLE, bit counter = 0, shift register = 0. Outputs during and after reset: sout_valid = 0, sout_last = 0, sout_data = 0, busy = 0, fifo_pop = 0 while fifo_empty = 1.
- Define load = ~fifo_empty & (state == IDLE | (sout_valid & sout_ready & sout_last)).
- fifo_pop = load, combinational. Never 1 while fifo_empty = 1; never 1 in SHIFT except on the accepted last bit.
- On load: shift register <= fifo_read_data, bit counter <= 0, state <= SHIFT. Latency: word at FIFO head at edge N -> first bit valid after edge N.
- In SHIFT:
  - sout_valid = 1.
  - sout_data = shift register bit 0 if lsb_first, else bit width-1.
  - sout_last = (bit counter == width-1).
- Accepted non-last bit (sout_valid & sout_ready & ~sout_last): shift register shifts one position toward the output end, zero-filled; bit counter + 1.
- Accepted last bit:
  - If load: reload immediately, with no bubble between words.
  - Else: state <= IDLE, bit counter <= 0.
  - Bit counter wraps explicitly at width-1 (correct for non-power-of-two widths such as 10).
- Stall: while sout_valid & ~sout_ready, sout_data, sout_last, counter and shift register hold stable; fifo_pop = 0.
- sout_ready is ignored in IDLE. fifo_read_data is ignored except on load cycles.
- FIFO becomes non-empty during SHIFT: no pop until the current last bit is accepted.
- Reset mid-word: the partially sent word is dropped, not replayed. sout_valid drops immediately.
- Throughput: exactly width accepted bits per popped word; one pop per width accepted bits at full rate.

Test Plan:
- Reset then single word: width=8, lsb_first=1, push 8'hA5, sout_ready=1 -> fifo_pop for one cycle; bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles; sout_last only on the 8th; then IDLE with sout_valid=0.
- Back-to-back: FIFO holds 8'h0F, 8'hF0, ready=1 -> 16 consecutive valid bits, 0F then F0 LSB-first; second fifo_pop coincides with the first word's last bit; no gap cycle.
- Backpressure: 8'h81, sout_ready toggled 1,0,0,1,... -> each bit held stable while ready=0; total 8 accepted bits = 1,0,0,0,0,0,0,1; fifo_pop never asserted during stalls.
- Stall on last bit with FIFO non-empty: ready=0 on bit 7 for 3 cycles -> fifo_pop stays 0 until ready=1, then pops the next word on that edge.
- MSB-first, non-power-of-two: width=10, lsb_first=0, word 10'h201 -> bits 1,0,0,0,0,0,0,0,0,1; counter wraps 9->0; sout_last on the 10th bit.
- Reset mid-word: assert rst after 3 accepted bits of 8'hFF with FIFO holding 8'h00 -> sout_valid=0 immediately. After release, the next word serialized is 8'h00, starting from bit 0.
